// File: rtl/raster_capture.sv
// Raster-order pixel sink: checks stream order, stores one frame, keeps counters, offers readback.
// Optional RASTER_CAPTURE_NEGA_EN inverts each pixel before it is stored and summed.
module raster_capture #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_WIDTH = 8,
    localparam int PIXELS = IMG_WIDTH * IMG_HEIGHT,
    localparam int HW     = $clog2(IMG_WIDTH),
    localparam int VW     = $clog2(IMG_HEIGHT),
    localparam int AW     = $clog2(PIXELS),
    localparam int CW     = $clog2(PIXELS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  in_valid,
    input  logic [HW-1:0]         in_hcount,
    input  logic [VW-1:0]         in_vcount,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic [CW-1:0]         pix_count,
    output logic [15:0]           err_count,
    output logic [31:0]           checksum,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    frame_done_q, frame_done_d;
    logic [CW-1:0]           pix_count_q, pix_count_d;
    logic [15:0]             err_count_q, err_count_d;
    logic [31:0]             checksum_q, checksum_d;
    logic [HW-1:0]           exp_h_q, exp_h_d;
    logic [VW-1:0]           exp_v_q, exp_v_d;
    logic [AW-1:0]           exp_addr_q, exp_addr_d;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic                    wr_en_s;
    logic                    accept_s;
    logic                    last_s;
    logic [DATA_WIDTH-1:0]   pix_data_s;
    logic [DATA_WIDTH-1:0]   mem [PIXELS];

`ifdef RASTER_CAPTURE_NEGA_EN
    assign pix_data_s = ~in_data;
`else
    assign pix_data_s = in_data;
`endif

    // The first beat is taken only at (0,0) while armed; in capture every valid beat is taken.
    assign accept_s = in_valid &&
                      (((state_q == ST_ARMED) && (in_hcount == {HW{1'b0}}) && (in_vcount == {VW{1'b0}})) ||
                       (state_q == ST_CAPTURE));
    assign last_s   = (exp_h_q == HW'(IMG_WIDTH - 1)) && (exp_v_q == VW'(IMG_HEIGHT - 1));

    // Next-state, counter and expected-position logic.
    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        pix_count_d  = pix_count_q;
        err_count_d  = err_count_q;
        checksum_d   = checksum_q;
        exp_h_d      = exp_h_q;
        exp_v_d      = exp_v_q;
        exp_addr_d   = exp_addr_q;
        wr_en_s      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d     = ST_ARMED;
                    pix_count_d = {CW{1'b0}};
                    err_count_d = 16'h0000;
                    checksum_d  = 32'h0000_0000;
                    exp_h_d     = {HW{1'b0}};
                    exp_v_d     = {VW{1'b0}};
                    exp_addr_d  = {AW{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_ARMED, ST_CAPTURE: begin
                if (accept_s) begin
                    wr_en_s     = 1'b1;
                    pix_count_d = pix_count_q + CW'(1);
                    checksum_d  = checksum_q + 32'(pix_data_s);
                    exp_addr_d  = exp_addr_q + AW'(1);
                    if (((in_hcount != exp_h_q) || (in_vcount != exp_v_q)) && (err_count_q != 16'hFFFF)) begin
                        err_count_d = err_count_q + 16'd1;
                    end else begin
                        err_count_d = err_count_q;
                    end
                    if (exp_h_q == HW'(IMG_WIDTH - 1)) begin
                        exp_h_d = {HW{1'b0}};
                        exp_v_d = exp_v_q + VW'(1);
                    end else begin
                        exp_h_d = exp_h_q + HW'(1);
                        exp_v_d = exp_v_q;
                    end
                    if (last_s) begin
                        state_d      = ST_DONE;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
    end

    // Control and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            pix_count_q  <= {CW{1'b0}};
            err_count_q  <= 16'h0000;
            checksum_q   <= 32'h0000_0000;
            exp_h_q      <= {HW{1'b0}};
            exp_v_q      <= {VW{1'b0}};
            exp_addr_q   <= {AW{1'b0}};
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            pix_count_q  <= pix_count_d;
            err_count_q  <= err_count_d;
            checksum_q   <= checksum_d;
            exp_h_q      <= exp_h_d;
            exp_v_q      <= exp_v_d;
            exp_addr_q   <= exp_addr_d;
        end
    end

    // Frame memory write; data goes to the expected address, never the incoming coordinates.
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst) begin
            mem[exp_addr_q] <= pix_data_s;
        end
    end

    // Registered readback; a same-cycle write is not forwarded, so the old word is returned.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= {DATA_WIDTH{1'b0}};
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign pix_count  = pix_count_q;
    assign err_count  = err_count_q;
    assign checksum   = checksum_q;
    assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_raster_capture.sv
// Directed bench for raster_capture on a 4x3 frame; honours RASTER_CAPTURE_NEGA_EN.
module tb_raster_capture;

    localparam int W = 4;
    localparam int H = 3;

`ifdef RASTER_CAPTURE_NEGA_EN
    localparam int CS_NORMAL = 2994;
    localparam int CS_SYNC   = 2754;
    localparam int RD5       = 250;
    localparam int RD11      = 244;
    localparam int RD20      = 235;
    localparam int RD3       = 252;
    localparam int RD4       = 251;
`else
    localparam int CS_NORMAL = 66;
    localparam int CS_SYNC   = 306;
    localparam int RD5       = 5;
    localparam int RD11      = 11;
    localparam int RD20      = 20;
    localparam int RD3       = 3;
    localparam int RD4       = 4;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_hcount = 2'd0;
    logic [1:0]  in_vcount = 2'd0;
    logic [7:0]  in_data = 8'd0;
    logic        busy;
    logic        frame_done;
    logic [3:0]  pix_count;
    logic [15:0] err_count;
    logic [31:0] checksum;
    logic [3:0]  rd_addr = 4'd0;
    logic [7:0]  rd_data;

    int tests_run = 0;
    int tests_failed = 0;

    raster_capture #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .arm(arm), .in_valid(in_valid),
        .in_hcount(in_hcount), .in_vcount(in_vcount), .in_data(in_data),
        .busy(busy), .frame_done(frame_done), .pix_count(pix_count),
        .err_count(err_count), .checksum(checksum),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input longint obs, input longint exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic beat(input int h, input int v, input int d);
        in_valid  = 1'b1;
        in_hcount = 2'(h);
        in_vcount = 2'(v);
        in_data   = 8'(d);
        step();
        in_valid  = 1'b0;
    endtask

    task automatic read_at(input int a, input string tag, input int exp);
        rd_addr = 4'(a);
        step();
        check_value(tag, rd_data, exp);
    endtask

    // Sends a full raster frame; checks frame_done timing on the last beat.
    task automatic send_frame(input int base, input bit gap, input string tag);
        for (int i = 0; i < W * H; i++) begin
            beat(i % W, i / W, base + i);
            if (i == W * H - 2) check_value({tag, "_done_early"}, frame_done, 0);
            if (i == W * H - 1) begin
                check_value({tag, "_done"}, frame_done, 1);
                check_value({tag, "_busy_end"}, busy, 0);
            end
            if (gap && i < W * H - 1) begin
                arm = (i == 5);
                step();
                arm = 1'b0;
            end
        end
        step();
        check_value({tag, "_done_pulse"}, frame_done, 0);
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        check_value("rst_busy", busy, 0);
        check_value("rst_done", frame_done, 0);
        check_value("rst_pix", pix_count, 0);
        check_value("rst_err", err_count, 0);
        check_value("rst_cs", checksum, 0);
        check_value("rst_rd", rd_data, 0);

        // Normal frame
        do_arm();
        check_value("norm_busy", busy, 1);
        send_frame(0, 1'b0, "norm");
        check_value("norm_pix", pix_count, 12);
        check_value("norm_err", err_count, 0);
        check_value("norm_cs", checksum, CS_NORMAL);
        read_at(5, "norm_rd5", RD5);

        // Gapped stream with a stray arm mid-frame
        do_arm();
        check_value("gap_clear", pix_count, 0);
        send_frame(0, 1'b1, "gap");
        check_value("gap_pix", pix_count, 12);
        check_value("gap_err", err_count, 0);
        check_value("gap_cs", checksum, CS_NORMAL);
        read_at(11, "gap_rd11", RD11);

        // Sync: ignored beats in IDLE and in ARMED off-origin
        do_reset();
        beat(0, 0, 99);
        check_value("sync_idle_pix", pix_count, 0);
        check_value("sync_idle_busy", busy, 0);
        do_arm();
        beat(2, 1, 77);
        beat(3, 1, 78);
        check_value("sync_armed_pix", pix_count, 0);
        check_value("sync_armed_err", err_count, 0);
        check_value("sync_armed_busy", busy, 1);
        send_frame(20, 1'b0, "sync");
        check_value("sync_pix", pix_count, 12);
        check_value("sync_cs", checksum, CS_SYNC);
        read_at(0, "sync_rd0", RD20);

        // Order error: beats 4 and 5 carry swapped coordinates
        do_arm();
        for (int i = 0; i < W * H; i++) begin
            if (i == 3) beat(0, 1, i);
            else if (i == 4) beat(3, 0, i);
            else beat(i % W, i / W, i);
        end
        check_value("ord_done", frame_done, 1);
        check_value("ord_err", err_count, 2);
        check_value("ord_pix", pix_count, 12);
        read_at(3, "ord_rd3", RD3);
        read_at(4, "ord_rd4", RD4);

        // Reset mid-frame, then a fresh full frame
        do_arm();
        for (int i = 0; i < 6; i++) beat(i % W, i / W, 50 + i);
        do_reset();
        check_value("mid_busy", busy, 0);
        check_value("mid_pix", pix_count, 0);
        check_value("mid_cs", checksum, 0);
        beat(0, 0, 1);
        check_value("mid_idle_pix", pix_count, 0);
        do_arm();
        send_frame(0, 1'b0, "rearm");
        check_value("rearm_pix", pix_count, 12);
        check_value("rearm_err", err_count, 0);
        check_value("rearm_cs", checksum, CS_NORMAL);
        read_at(5, "rearm_rd5", RD5);

`ifdef RASTER_CAPTURE_NEGA_EN
        // Inversion: 0x10 stores as 0xEF; all-zero frame sums to 12*255
        do_arm();
        beat(0, 0, 8'h10);
        for (int i = 1; i < W * H; i++) beat(i % W, i / W, 0);
        check_value("nega_done", frame_done, 1);
        check_value("nega_cs", checksum, 3060 - 255 + 8'hEF);
        read_at(0, "nega_rd0", 8'hEF);
        do_arm();
        for (int i = 0; i < W * H; i++) beat(i % W, i / W, 0);
        check_value("nega_zero_cs", checksum, 3060);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
